// File: rtl/sram_mem_controller_if.sv
// ----------------------------------------------------------------------------
// sram_mem_controller_if
//   Pipeline-side bus between the MEM stage and the SRAM controller.
//
//   Handshake: the MEM stage raises rd_en or wr_en together with address and
//   write_data, and holds all of them stable while ready=0. The access is
//   finished in the cycle where ready=1; the pipeline advances on the clock
//   edge that ends that cycle. With no request pending, ready sits at 1.
//
//   Signals
//     wr_en       master->slave  store request
//     rd_en       master->slave  load request
//     address     master->slave  byte address, bits [1:0] ignored
//     write_data  master->slave  store data
//     read_data   slave->master  load result
//     ready       slave->master  1 = MEM stage may advance
//   Modports
//     master  pipeline (MEM stage) side
//     slave   controller side
// ----------------------------------------------------------------------------
interface sram_mem_controller_if;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;

   modport master (
      output wr_en, rd_en, address, write_data,
      input  read_data, ready
   );

   modport slave (
      input  wr_en, rd_en, address, write_data,
      output read_data, ready
   );
endinterface

// File: rtl/sram_mem_controller.sv
// ----------------------------------------------------------------------------
// sram_mem_controller
//   Sequences a 16-bit asynchronous SRAM for the MEM stage. Each 32-bit
//   load/store becomes two half-word accesses (low half, then high half) of
//   WAIT_CYCLES clocks each, followed by a one-cycle DONE state in which
//   ready=1. Request-to-ready latency is 2*WAIT_CYCLES+1 cycles.
//
//   Ports
//     clk          rising-edge clock
//     rst          synchronous active-high reset
//     mem          pipeline bus (slave modport): wr_en, rd_en, address,
//                  write_data in; read_data, ready out
//     sram_addr    SRAM half-word address
//     sram_dq_out  data driven towards the SRAM
//     sram_dq_oe   1 = top level drives sram_dq_out onto the bus
//     sram_dq_in   data read back from the SRAM bus
//     sram_we_n    SRAM write strobe, active low
//     dbg_state    current FSM state (0 IDLE, 1 LOW, 2 HIGH, 3 DONE)
// ----------------------------------------------------------------------------
module sram_mem_controller #(
   parameter int          WAIT_CYCLES = 3,
   parameter int unsigned BASE_ADDR   = 1024,
   parameter int          SRAM_AW     = 18
) (
   input  logic                  clk,
   input  logic                  rst,
   sram_mem_controller_if.slave  mem,
   output logic [SRAM_AW-1:0]    sram_addr,
   output logic [15:0]           sram_dq_out,
   output logic                  sram_dq_oe,
   input  logic [15:0]           sram_dq_in,
   output logic                  sram_we_n,
   output logic [1:0]            dbg_state
);

   localparam int CW = $clog2(WAIT_CYCLES + 1);
   localparam logic [CW-1:0] LAST_COUNT = CW'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      count_q, count_d;
   logic               is_wr_q, is_wr_d;
   logic [SRAM_AW-2:0] word_q, word_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [31:0]        read_data_q, read_data_d;

   logic [31:0]        addr_off;
   logic               last_cycle;

   // Addresses below BASE_ADDR wrap through the subtraction; the cast keeps
   // the word index modulo 2^(SRAM_AW-1).
   assign addr_off   = mem.address - 32'(BASE_ADDR);
   assign last_cycle = (count_q == LAST_COUNT);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         is_wr_q     <= 1'b0;
         word_q      <= '0;
         wdata_q     <= '0;
         read_data_q <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         is_wr_q     <= is_wr_d;
         word_q      <= word_d;
         wdata_q     <= wdata_d;
         read_data_q <= read_data_d;
      end
   end

   // Next-state logic, including operation capture and read-data sampling
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      is_wr_d     = is_wr_q;
      word_d      = word_q;
      wdata_d     = wdata_q;
      read_data_d = read_data_q;
      case (state_q)
         IDLE: begin
            count_d = '0;
            if (mem.rd_en || mem.wr_en) begin
               // A store wins when both requests are raised.
               is_wr_d = mem.wr_en;
               word_d  = (SRAM_AW-1)'(addr_off >> 2);
               wdata_d = mem.write_data;
               state_d = LOW;
            end
         end
         LOW: begin
            if (last_cycle) begin
               count_d = '0;
               state_d = HIGH;
               if (!is_wr_q) read_data_d[15:0] = sram_dq_in;
            end else begin
               count_d = count_q + CW'(1);
            end
         end
         HIGH: begin
            if (last_cycle) begin
               count_d = '0;
               state_d = DONE;
               if (!is_wr_q) read_data_d[31:16] = sram_dq_in;
            end else begin
               count_d = count_q + CW'(1);
            end
         end
         DONE: begin
            // A request still held here belongs to the finished access; it is
            // looked at again in IDLE on the next cycle.
            count_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      mem.ready   = 1'b0;
      sram_addr   = '0;
      sram_dq_out = '0;
      sram_dq_oe  = 1'b0;
      sram_we_n   = 1'b1;
      case (state_q)
         IDLE: mem.ready = !(mem.rd_en || mem.wr_en);
         LOW: begin
            sram_addr = {word_q, 1'b0};
            if (is_wr_q) begin
               sram_dq_out = wdata_q[15:0];
               sram_dq_oe  = 1'b1;
               sram_we_n   = 1'b0;
            end
         end
         HIGH: begin
            sram_addr = {word_q, 1'b1};
            if (is_wr_q) begin
               sram_dq_out = wdata_q[31:16];
               sram_dq_oe  = 1'b1;
               sram_we_n   = 1'b0;
            end
         end
         DONE: mem.ready = 1'b1;
         default: mem.ready = 1'b0;
      endcase
   end

   assign mem.read_data = read_data_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// ----------------------------------------------------------------------------
// tb_sram_mem_controller
//   Directed bench for sram_mem_controller with a small behavioural SRAM.
//   The driver task issues one access and checks the per-cycle SRAM bus and
//   the latency; the expected read_data of every access goes into exp_q and
//   a separate monitor compares it when the DUT reaches DONE.
// ----------------------------------------------------------------------------
module tb_sram_mem_controller;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HIGH = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_in;
   logic        sram_we_n;
   logic [1:0]  dbg_state;

   sram_mem_controller_if bus ();

   sram_mem_controller dut (
      .clk         (clk),
      .rst         (rst),
      .mem         (bus),
      .sram_addr   (sram_addr),
      .sram_dq_out (sram_dq_out),
      .sram_dq_oe  (sram_dq_oe),
      .sram_dq_in  (sram_dq_in),
      .sram_we_n   (sram_we_n),
      .dbg_state   (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- SRAM model ----------------
   // 256 half-words, indexed by the low address bits. A cycle in which reset
   // is asserted counts as aborted, so its write strobe does not land.
   logic [15:0] mem_arr [0:255];
   logic        pre_we;
   logic [7:0]  pre_addr;
   logic [15:0] pre_data;

   always @(posedge clk) begin
      if (pre_we) mem_arr[pre_addr] <= pre_data;
      else if (!sram_we_n && !rst) mem_arr[sram_addr[7:0]] <= sram_dq_out;
   end

   assign sram_dq_in = mem_arr[sram_addr[7:0]];

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q[$];
   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Monitor: every DONE cycle presents one response.
   always @(negedge clk) begin
      if (!rst && dbg_state == S_DONE && bus.ready) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_done", 32'd1, 32'd0);
         end else begin
            chk("sb_read_data", bus.read_data, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic preload(input logic [7:0] a, input logic [15:0] d);
      pre_we   = 1'b1;
      pre_addr = a;
      pre_data = d;
      @(posedge clk); #1;
      pre_we   = 1'b0;
   endtask

   // Called #1 after a clock edge with the FSM in IDLE. Returns #1 after the
   // edge that ends DONE, with the request still driven.
   task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [16:0] exp_word,
                             input logic [31:0] exp_rdata);
      int          lat    = 0;
      int          we_cnt = 0;
      logic        is_wr  = wr;
      logic [17:0] exp_addr;
      exp_q.push_back(exp_rdata);
      bus.rd_en      = rd;
      bus.wr_en      = wr;
      bus.address    = addr;
      bus.write_data = wdata;
      #1;
      chk("req_ready_low", {31'd0, bus.ready}, 32'd0);
      while (lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (bus.ready) break;
         exp_addr = {exp_word, (lat > 3) ? 1'b1 : 1'b0};
         chk("sram_addr", {14'd0, sram_addr}, {14'd0, exp_addr});
         chk("sram_we_n", {31'd0, sram_we_n}, {31'd0, !is_wr});
         chk("sram_dq_oe", {31'd0, sram_dq_oe}, {31'd0, is_wr});
         if (is_wr)
            chk("sram_dq_out", {16'd0, sram_dq_out},
                {16'd0, (lat > 3) ? wdata[31:16] : wdata[15:0]});
         if (!sram_we_n) we_cnt++;
      end
      chk("latency", lat, 32'd7);
      chk("we_low_cycles", we_cnt, is_wr ? 32'd6 : 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic end_access();
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst            = 1'b1;
      bus.rd_en      = 1'b0;
      bus.wr_en      = 1'b0;
      bus.address    = '0;
      bus.write_data = '0;
      pre_we         = 1'b0;
      pre_addr       = '0;
      pre_data       = '0;

      // 1. Reset
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, bus.ready}, 32'd1);
      chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
      chk("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
      chk("rst_read_data", bus.read_data, 32'd0);
      chk("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
      chk("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
      rst = 1'b0;

      preload(8'd0, 16'h0000);
      preload(8'd1, 16'h0000);
      preload(8'd2, 16'hBEEF);
      preload(8'd3, 16'h1234);
      preload(8'd4, 16'h0000);
      preload(8'd5, 16'hFFFF);

      // 2. Read at 1028 -> word 1, half-words 2 and 3
      run_access(1'b1, 1'b0, 32'd1028, 32'd0, 17'd1, 32'h1234BEEF);
      end_access();

      // 3. Write at 1024; read_data keeps the previous load
      run_access(1'b0, 1'b1, 32'd1024, 32'hCAFEF00D, 17'd0, 32'h1234BEEF);
      end_access();
      chk("wr_mem0", {16'd0, mem_arr[0]}, 32'h0000F00D);
      chk("wr_mem1", {16'd0, mem_arr[1]}, 32'h0000CAFE);

      // 4. Both requests at 1032: the write wins
      run_access(1'b1, 1'b1, 32'd1032, 32'h00000005, 17'd2, 32'h1234BEEF);
      end_access();
      chk("both_mem4", {16'd0, mem_arr[4]}, 32'h00000005);
      chk("both_mem5", {16'd0, mem_arr[5]}, 32'h00000000);

      // 5. Back-to-back reads, rd_en never dropped
      run_access(1'b1, 1'b0, 32'd1024, 32'd0, 17'd0, 32'hCAFEF00D);
      chk("b2b_gap_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
      run_access(1'b1, 1'b0, 32'd1028, 32'd0, 17'd1, 32'h1234BEEF);
      end_access();

      // 6. Reset during the HIGH phase of a write
      bus.wr_en      = 1'b1;
      bus.address    = 32'd1024;
      bus.write_data = 32'hAAAA5555;
      repeat (4) @(posedge clk);
      #1;
      chk("abort_in_high", {30'd0, dbg_state}, {30'd0, S_HIGH});
      rst       = 1'b1;
      bus.wr_en = 1'b0;
      @(posedge clk); #1;
      chk("abort_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
      chk("abort_we_n", {31'd0, sram_we_n}, 32'd1);
      chk("abort_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
      chk("abort_ready", {31'd0, bus.ready}, 32'd1);
      chk("abort_read_data", bus.read_data, 32'd0);
      rst = 1'b0;
      chk("abort_mem0", {16'd0, mem_arr[0]}, 32'h00005555);
      chk("abort_mem1", {16'd0, mem_arr[1]}, 32'h0000CAFE);

      // 7. Address below BASE_ADDR wraps: (0-1024)>>2 mod 2^17 = 17'h1FF00.
      // The model aliases that onto half-words 0 and 1.
      @(posedge clk); #1;
      run_access(1'b1, 1'b0, 32'd0, 32'd0, 17'h1FF00, 32'hCAFE5555);
      end_access();

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
